ghr_ckpt_shiftreg: RTL and testbench

Speculative global-history shift register for the perceptron branch predictor. Each predicted branch is shifted into the history and receives a checkpoint tag. On resolution the branch either commits in order or triggers a misprediction fix: the history is restored from the tag's checkpoint with the correct outcome, and all younger checkpoints are discarded. The block sits between the predictor front end (shifts) and branch resolution (commit/fix). It keeps the write-all load of the plain history shift register.

---
 rtl/ghr_ckpt_shiftreg.sv | 167 ++++++++++++++++
 tb/tb_ghr_ckpt_shiftreg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghr_ckpt_shiftreg.sv
// Speculative global history with per-branch checkpoints; GHR_RETIRED_HIST_EN adds retired history and retire_flush.
// Latency: out/count/full/empty update one cycle after the event; spec_ready/spec_tag are same-cycle.
// Backpressure: spec_ready drops when full or while fix/we (or retire_flush) is asserted; refused shifts are dropped.
module ghr_ckpt_shiftreg #(
    parameter int HIST_LEN   = 32,
    parameter int CKPT_DEPTH = 8,
    localparam int TAG_W     = $clog2(CKPT_DEPTH),
    localparam int CNT_W     = TAG_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [HIST_LEN-1:0] datain,
    input  logic                spec_valid,
    input  logic                shiftin,
    output logic                spec_ready,
    output logic [TAG_W-1:0]    spec_tag,
    input  logic                commit_valid,
    input  logic                fix_valid,
    input  logic [TAG_W-1:0]    fix_tag,
    input  logic                fix_bit,
`ifdef GHR_RETIRED_HIST_EN
    input  logic                retire_flush,
    output logic [HIST_LEN-1:0] retired_out,
`endif
    output logic [HIST_LEN-1:0] out,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty
);

    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CKPT_DEPTH);

    logic [HIST_LEN-1:0] hist_q, hist_d;
    logic [TAG_W-1:0]    head_q, head_d;
    logic [TAG_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    fix_cnt;
    logic                full_q, empty_q;
    logic                flush;
    logic                shift_acc;
    logic                commit_acc;

    // The MSB of a checkpoint falls off on restore, so only the low bits are kept.
    logic [HIST_LEN-2:0] ckpt_hist [CKPT_DEPTH];

`ifdef GHR_RETIRED_HIST_EN
    logic [CKPT_DEPTH-1:0] ckpt_bit;
    logic [HIST_LEN-1:0]   retired_q, retired_d;
    logic                  retire_bit;
    assign flush = retire_flush;
`else
    assign flush = 1'b0;
`endif

    assign spec_ready = !full_q && !fix_valid && !we && !flush;
    assign spec_tag   = tail_q;
    assign shift_acc  = spec_valid && spec_ready;
    // A fix overrides we/flush, so a commit alongside a fix still retires.
    assign commit_acc = commit_valid && !empty_q && (fix_valid || !(we || flush));
    assign fix_cnt    = {1'b0, fix_tag - head_q} + CNT_ONE;

    always_comb begin
        hist_d  = hist_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fix_valid) begin
            hist_d  = {ckpt_hist[fix_tag], fix_bit};
            tail_d  = fix_tag + TAG_ONE;
            count_d = fix_cnt;
            if (commit_acc) begin
                head_d  = head_q + TAG_ONE;
                count_d = fix_cnt - CNT_ONE;
            end
`ifdef GHR_RETIRED_HIST_EN
        end else if (flush) begin
            hist_d  = retired_q;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
`endif
        end else if (we) begin
            hist_d  = datain;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (shift_acc) begin
                hist_d = {hist_q[HIST_LEN-2:0], shiftin};
                tail_d = tail_q + TAG_ONE;
            end
            if (commit_acc) begin
                head_d = head_q + TAG_ONE;
            end
            if (shift_acc && !commit_acc) begin
                count_d = count_q + CNT_ONE;
            end else if (!shift_acc && commit_acc) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            hist_q  <= hist_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_MAX);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (shift_acc) begin
            ckpt_hist[tail_q] <= hist_q[HIST_LEN-2:0];
        end
    end

`ifdef GHR_RETIRED_HIST_EN
    always_comb begin
        // A branch fixed and retired in the same cycle retires with its corrected outcome.
        retire_bit = (fix_valid && (fix_tag == head_q)) ? fix_bit : ckpt_bit[head_q];
        retired_d  = retired_q;
        if (commit_acc) begin
            retired_d = {retired_q[HIST_LEN-2:0], retire_bit};
        end else if (we && !fix_valid && !flush) begin
            retired_d = datain;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_acc) begin
            ckpt_bit[tail_q] <= shiftin;
        end
        if (fix_valid) begin
            ckpt_bit[fix_tag] <= fix_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_out = retired_q;
`endif

    assign out   = hist_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_ghr_ckpt_shiftreg.sv
// Bench for ghr_ckpt_shiftreg (HIST_LEN=8, CKPT_DEPTH=4): directed vector table, reset/retire sequences,
// then random traffic against a queue-based model of the outstanding branches.
`timescale 1ns/1ps
module tb_ghr_ckpt_shiftreg;
    localparam int HL = 8;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [7:0] datain;
    logic       spec_valid;
    logic       shiftin;
    logic       spec_ready;
    logic [1:0] spec_tag;
    logic       commit_valid;
    logic       fix_valid;
    logic [1:0] fix_tag;
    logic       fix_bit;
    logic [7:0] out;
    logic [2:0] count;
    logic       full;
    logic       empty;
`ifdef GHR_RETIRED_HIST_EN
    logic       retire_flush;
    logic [7:0] retired_out;
`endif

    ghr_ckpt_shiftreg #(.HIST_LEN(HL), .CKPT_DEPTH(CD)) dut (
        .clk(clk), .reset(reset), .we(we), .datain(datain),
        .spec_valid(spec_valid), .shiftin(shiftin),
        .spec_ready(spec_ready), .spec_tag(spec_tag),
        .commit_valid(commit_valid), .fix_valid(fix_valid),
        .fix_tag(fix_tag), .fix_bit(fix_bit),
`ifdef GHR_RETIRED_HIST_EN
        .retire_flush(retire_flush), .retired_out(retired_out),
`endif
        .out(out), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: history as an integer, outstanding branches as queues, oldest first.
    int m_hist, m_ret, m_head;
    int q_pre[$];
    int q_bit[$];
    int e_rdy, e_tag;
    logic       s_rdy;
    logic [1:0] s_tag;

    typedef struct {
        int we, din, sv, si, cv, fv, ft, fb;
        int e_rdy, e_tag, e_out, e_cnt, e_full, e_empty;
    } vec_t;
    vec_t tbl[23];

    function automatic vec_t mk(int we_i, int din_i, int sv_i, int si_i, int cv_i, int fv_i, int ft_i,
                                int fb_i, int rdy_i, int tag_i, int out_i, int cnt_i, int full_i, int emp_i);
        vec_t v;
        v.we = we_i; v.din = din_i; v.sv = sv_i; v.si = si_i; v.cv = cv_i;
        v.fv = fv_i; v.ft = ft_i; v.fb = fb_i;
        v.e_rdy = rdy_i; v.e_tag = tag_i; v.e_out = out_i; v.e_cnt = cnt_i;
        v.e_full = full_i; v.e_empty = emp_i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 0; m_ret = 0; m_head = 0;
        q_pre.delete(); q_bit.delete();
    endtask

    task automatic model_retire();
        m_ret = ((m_ret << 1) | q_bit[0]) & 255;
        void'(q_pre.pop_front());
        void'(q_bit.pop_front());
        m_head = (m_head + 1) % CD;
    endtask

    task automatic model_step(input int i_we, input int i_din, input int i_sv, input int i_si,
                              input int i_cv, input int i_fv, input int i_ft, input int i_fb,
                              input int i_rf);
        int n, idx;
        n = q_pre.size();
        e_rdy = (n != CD && i_fv == 0 && i_we == 0 && i_rf == 0) ? 1 : 0;
        e_tag = (m_head + n) % CD;
        if (i_fv != 0) begin
            idx = (i_ft - m_head + CD) % CD;
            if (idx >= n) begin
                fails++;
                $display("FAIL illegal_fix_tag: tag %0d outside %0d outstanding from head %0d", i_ft, n, m_head);
            end else begin
                m_hist = ((q_pre[idx] << 1) | i_fb) & 255;
                q_bit[idx] = i_fb;
                while (q_pre.size() > idx + 1) begin
                    void'(q_pre.pop_back());
                    void'(q_bit.pop_back());
                end
                if (i_cv != 0) model_retire();
            end
        end else if (i_rf != 0) begin
            m_hist = m_ret;
            q_pre.delete(); q_bit.delete(); m_head = 0;
        end else if (i_we != 0) begin
            m_hist = i_din & 255;
            m_ret  = i_din & 255;
            q_pre.delete(); q_bit.delete(); m_head = 0;
        end else begin
            if (e_rdy != 0 && i_sv != 0) begin
                q_pre.push_back(m_hist);
                q_bit.push_back(i_si);
                m_hist = ((m_hist << 1) | i_si) & 255;
            end
            if (i_cv != 0 && n > 0) model_retire();
        end
    endtask

    task automatic idle();
        we = 0; datain = 0; spec_valid = 0; shiftin = 0;
        commit_valid = 0; fix_valid = 0; fix_tag = 0; fix_bit = 0;
`ifdef GHR_RETIRED_HIST_EN
        retire_flush = 0;
`endif
    endtask

    task automatic step(input int i_we, input int i_din, input int i_sv, input int i_si,
                        input int i_cv, input int i_fv, input int i_ft, input int i_fb,
                        input int i_rf);
        @(negedge clk);
        we = i_we[0]; datain = i_din[7:0]; spec_valid = i_sv[0]; shiftin = i_si[0];
        commit_valid = i_cv[0]; fix_valid = i_fv[0]; fix_tag = i_ft[1:0]; fix_bit = i_fb[0];
`ifdef GHR_RETIRED_HIST_EN
        retire_flush = i_rf[0];
`endif
        #1;
        s_rdy = spec_ready;
        s_tag = spec_tag;
        model_step(i_we, i_din, i_sv, i_si, i_cv, i_fv, i_ft, i_fb, i_rf);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string pfx);
        chk({pfx, "_rdy"}, 32'(s_rdy), e_rdy);
        chk({pfx, "_tag"}, 32'(s_tag), e_tag);
        chk({pfx, "_out"}, 32'(out), m_hist);
        chk({pfx, "_cnt"}, 32'(count), q_pre.size());
        chk({pfx, "_full"}, 32'(full), (q_pre.size() == CD) ? 1 : 0);
        chk({pfx, "_empty"}, 32'(empty), (q_pre.size() == 0) ? 1 : 0);
`ifdef GHR_RETIRED_HIST_EN
        chk({pfx, "_ret"}, 32'(retired_out), m_ret);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        //            we din  sv si cv fv ft fb | rdy tag out  cnt full empty
        tbl[0]  = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 0, 'h01, 1, 0, 0);
        tbl[1]  = mk(0, 0,    1, 0, 0, 0, 0, 0,   1, 1, 'h02, 2, 0, 0);
        tbl[2]  = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 2, 'h05, 3, 0, 0);
        tbl[3]  = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 3, 'h0B, 4, 1, 0);
        tbl[4]  = mk(0, 0,    1, 1, 0, 0, 0, 0,   0, 0, 'h0B, 4, 1, 0);
        tbl[5]  = mk(0, 0,    0, 0, 0, 1, 1, 1,   0, 0, 'h03, 2, 0, 0);
        tbl[6]  = mk(0, 0,    1, 0, 0, 0, 0, 0,   1, 2, 'h06, 3, 0, 0);
        tbl[7]  = mk(1, 'hA5, 1, 1, 1, 0, 0, 0,   0, 3, 'hA5, 0, 0, 1);
        tbl[8]  = mk(1, 'h10, 0, 0, 0, 0, 0, 0,   0, 0, 'h10, 0, 0, 1);
        tbl[9]  = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 0, 'h21, 1, 0, 0);
        tbl[10] = mk(0, 0,    0, 0, 1, 1, 0, 0,   0, 1, 'h20, 0, 0, 1);
        tbl[11] = mk(0, 0,    0, 0, 1, 0, 0, 0,   1, 1, 'h20, 0, 0, 1);
        tbl[12] = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 1, 'h41, 1, 0, 0);
        tbl[13] = mk(0, 0,    1, 0, 1, 0, 0, 0,   1, 2, 'h82, 1, 0, 0);
        tbl[14] = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 3, 'h05, 2, 0, 0);
        tbl[15] = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 0, 'h0B, 3, 0, 0);
        tbl[16] = mk(0, 0,    1, 1, 0, 0, 0, 0,   1, 1, 'h17, 4, 1, 0);
        tbl[17] = mk(0, 0,    1, 0, 1, 0, 0, 0,   0, 2, 'h17, 3, 0, 0);
        tbl[18] = mk(0, 0,    1, 0, 0, 0, 0, 0,   1, 2, 'h2E, 4, 1, 0);
        tbl[19] = mk(1, 'hFF, 0, 0, 0, 1, 0, 0,   0, 3, 'h0A, 2, 0, 0);
        tbl[20] = mk(0, 0,    0, 0, 1, 0, 0, 0,   1, 1, 'h0A, 1, 0, 0);
        tbl[21] = mk(0, 0,    0, 0, 1, 0, 0, 0,   1, 1, 'h0A, 0, 0, 1);
        tbl[22] = mk(0, 0,    0, 0, 1, 0, 0, 0,   1, 1, 'h0A, 0, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rdy", 32'(spec_ready), 1);
        chk("rst_tag", 32'(spec_tag), 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].we, tbl[i].din, tbl[i].sv, tbl[i].si, tbl[i].cv,
                 tbl[i].fv, tbl[i].ft, tbl[i].fb, 0);
            chk($sformatf("tbl%0d_rdy", i), 32'(s_rdy), tbl[i].e_rdy);
            chk($sformatf("tbl%0d_tag", i), 32'(s_tag), tbl[i].e_tag);
            chk($sformatf("tbl%0d_out", i), 32'(out), tbl[i].e_out);
            chk($sformatf("tbl%0d_cnt", i), 32'(count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_full", i), 32'(full), tbl[i].e_full);
            chk($sformatf("tbl%0d_empty", i), 32'(empty), tbl[i].e_empty);
        end

`ifdef GHR_RETIRED_HIST_EN
        do_reset();
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("ret_hist", 32'(retired_out), 'h06);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_out", 32'(out), 'h06);
        chk("flush_cnt", 32'(count), 0);
`endif

        // Reset dropped in the middle of traffic clears state immediately.
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        reset = 1;
        model_reset();
        #1;
        chk("midrst_out", 32'(out), 0);
        chk("midrst_cnt", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_rdy", 32'(spec_ready), 1);
        chk("midrst_tag", 32'(spec_tag), 0);
        @(negedge clk);
        reset = 0;
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        check_model("postrst");

        for (int c = 0; c < 3000; c++) begin
            automatic int n    = q_pre.size();
            automatic int r_we = ($urandom_range(0, 31) == 0) ? 1 : 0;
            automatic int r_rf = 0;
            automatic int r_fv = 0;
            automatic int r_ft = 0;
            if (n > 0 && $urandom_range(0, 7) == 0) begin
                r_fv = 1;
                r_ft = (m_head + int'($urandom_range(0, n - 1))) % CD;
            end
`ifdef GHR_RETIRED_HIST_EN
            r_rf = ($urandom_range(0, 31) == 0) ? 1 : 0;
`endif
            step(r_we, int'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1 : 0,
                 r_fv, r_ft, int'($urandom_range(0, 1)), r_rf);
            check_model($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
